// File: rtl/hamming_pkg.sv
// hamming_pkg: shared widths, codeword layout and encoder state type for the Hamming(12,8) stripe path
package hamming_pkg;
  localparam int DATA_W = 8;
  localparam int CODE_W = 12;
  localparam int ADDR_W = 8;
  localparam int SYND_W = 4;
  localparam int P1_POS = 0;
  localparam int P2_POS = 1;
  localparam int P4_POS = 3;
  localparam int P8_POS = 7;
  typedef enum logic {S_DATA, S_PARITY} enc_state_t;
endpackage

// File: rtl/hamming_enc12.sv
// hamming_enc12: combinational 8->12 Hamming encoder, data at non-power-of-two positions
module hamming_enc12
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] d,
  output logic [CODE_W-1:0] c
);
  logic p1, p2, p4, p8;
  assign p1 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
  assign p2 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
  assign p4 = d[1] ^ d[2] ^ d[3] ^ d[7];
  assign p8 = d[4] ^ d[5] ^ d[6] ^ d[7];
  // parity bits land at P1_POS/P2_POS/P4_POS/P8_POS
  assign c = {d[7:4], p8, d[3:1], p4, d[0], p2, p1};
endmodule

// File: rtl/hamming_stripe_encoder.sv
// hamming_stripe_encoder: encodes data words and inserts an XOR parity codeword after each stripe
module hamming_stripe_encoder
  import hamming_pkg::*;
#(
  parameter int STRIPE_LEN = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] address_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] enc_data,
  output logic [ADDR_W-1:0] address_out,
  output logic              out_is_parity,
  output logic [CNT_W-1:0]  stripe_idx
);
  enc_state_t        state;
  logic [DATA_W-1:0] acc;
  logic [ADDR_W-1:0] last_addr;
  logic [CODE_W-1:0] enc_d, enc_p;
  logic [CNT_W-1:0]  idx_nxt;
  logic              slot_free, accept, emit_par;
  hamming_enc12 u_enc_data (.d(data_in), .c(enc_d));
  hamming_enc12 u_enc_par  (.d(acc),     .c(enc_p));
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == S_DATA) && slot_free;
  assign accept    = in_valid && in_ready;
  assign emit_par  = (state == S_PARITY) && slot_free;
  assign idx_nxt   = stripe_idx + 1'b1;
  // output register, stripe accumulator and data/parity sequencing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_DATA;
      acc           <= '0;
      last_addr     <= '0;
      stripe_idx    <= '0;
      out_valid     <= 1'b0;
      enc_data      <= '0;
      address_out   <= '0;
      out_is_parity <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      enc_data      <= enc_d;
      address_out   <= address_in;
      out_is_parity <= 1'b0;
      acc           <= acc ^ data_in;
      stripe_idx    <= idx_nxt;
      last_addr     <= address_in;
      if (idx_nxt == CNT_W'(STRIPE_LEN) || flush) state <= S_PARITY;
    end else if (emit_par) begin
      out_valid     <= 1'b1;
      enc_data      <= enc_p;
      address_out   <= last_addr;
      out_is_parity <= 1'b1;
      acc           <= '0;
      stripe_idx    <= '0;
      state         <= S_DATA;
    end else begin
      if (slot_free) out_valid <= 1'b0;
      if (state == S_DATA && flush && stripe_idx != '0) state <= S_PARITY;
    end
  end
endmodule

// File: tb/tb_hamming_stripe_encoder.sv
// tb_hamming_stripe_encoder: directed and randomized checks against a transaction-level stripe model
module tb_hamming_stripe_encoder;
  localparam int SL = 4;
  typedef struct {
    logic [11:0] c;
    logic [7:0]  a;
    logic        p;
  } exp_t;
  logic        clk = 0, reset = 1;
  logic        in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 1, out_is_parity;
  logic [7:0]  data_in = 0, address_in = 0, address_out;
  logic [11:0] enc_data;
  logic [7:0]  stripe_idx;
  int checks = 0, failures = 0;
  exp_t q[$];
  logic [7:0] m_acc = 0, m_last = 0;
  int m_cnt = 0, accepted = 0;
  bit last_ir;
  hamming_stripe_encoder #(.STRIPE_LEN(SL), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .address_in(address_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .enc_data(enc_data),
    .address_out(address_out), .out_is_parity(out_is_parity), .stripe_idx(stripe_idx)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] enc(input logic [7:0] d);
    logic [11:0] c = '0;
    int j = 0;
    for (int pos = 1; pos <= 12; pos++)
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[j];
        j++;
      end
    for (int b = 0; b < 4; b++)
      for (int pos = 1; pos <= 12; pos++)
        if (((pos >> b) & 1) == 1 && pos != (1 << b)) c[(1<<b)-1] ^= c[pos-1];
    return c;
  endfunction
  function automatic logic [3:0] synd(input logic [11:0] c);
    logic [3:0] s = '0;
    for (int pos = 1; pos <= 12; pos++) if (c[pos-1]) s ^= 4'(pos);
    return s;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input bit iv, input logic [7:0] d, input logic [7:0] a, input bit fl, input bit ordy);
    exp_t e;
    @(negedge clk);
    in_valid = iv; data_in = d; address_in = a; flush = fl; out_ready = ordy;
    #1;
    last_ir = in_ready;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_output", {19'd0, out_is_parity, enc_data}, 32'hDEAD);
      else begin
        e = q.pop_front();
        chk("sb_enc", enc_data, e.c);
        chk("sb_addr", address_out, e.a);
        chk("sb_par", out_is_parity, e.p);
      end
      chk("synd_zero", synd(enc_data), 0);
    end
    if (in_valid && in_ready) begin
      q.push_back('{enc(d), a, 1'b0});
      m_acc ^= d; m_cnt++; m_last = a; accepted++;
    end
    if (m_cnt > 0 && (m_cnt == SL || fl)) begin
      q.push_back('{enc(m_acc), m_last, 1'b1});
      m_acc = 0; m_cnt = 0;
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    in_valid = 0; flush = 0; reset = 1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_enc", enc_data, 0);
    chk("rst_addr", address_out, 0);
    chk("rst_par", out_is_parity, 0);
    chk("rst_idx", stripe_idx, 0);
    q.delete(); m_acc = 0; m_cnt = 0;
    @(negedge clk);
    reset = 0;
  endtask
  initial begin
    int cyc;
    do_reset();
    step(1, 8'h01, 8'h10, 0, 1);
    step(1, 8'hFF, 8'h11, 0, 1);
    chk("w1_valid", out_valid, 1);
    chk("w1_enc", enc_data, 12'h007);
    chk("w1_addr", address_out, 8'h10);
    chk("w1_par", out_is_parity, 0);
    step(1, 8'h00, 8'h12, 0, 1);
    chk("w2_enc", enc_data, 12'hF77);
    step(0, 8'h00, 8'h00, 0, 1);
    chk("w3_enc", enc_data, 12'h000);
    for (int b = 0; b < 12; b++) chk("flip_synd", synd(12'hF77 ^ (12'd1 << b)), b + 1);
    do_reset();
    step(1, 8'hFF, 8'h00, 0, 1);
    step(1, 8'h00, 8'h01, 0, 1);
    step(1, 8'h00, 8'h02, 0, 1);
    step(1, 8'h00, 8'h03, 0, 1);
    step(1, 8'h55, 8'h04, 0, 1);
    chk("full_ir_low", last_ir, 0);
    chk("full_idx", stripe_idx, SL);
    step(1, 8'h55, 8'h04, 0, 1);
    chk("full_ir_back", last_ir, 1);
    chk("full_par_enc", enc_data, 12'hF77);
    chk("full_par_addr", address_out, 8'h03);
    chk("full_par_flag", out_is_parity, 1);
    chk("full_idx_clr", stripe_idx, 0);
    do_reset();
    step(1, 8'hAA, 8'h05, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 8'(i), 8'h20, 0, 0);
      chk("bp_ir", last_ir, 0);
      chk("bp_hold_enc", enc_data, enc(8'hAA));
      chk("bp_hold_addr", address_out, 8'h05);
    end
    step(1, 8'h5A, 8'h06, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 8'h00, 8'h00, 0, 1);
    chk("bp_drained", q.size(), 0);
    do_reset();
    step(1, 8'h01, 8'h30, 0, 1);
    step(1, 8'h02, 8'h31, 0, 1);
    step(0, 8'h00, 8'h00, 1, 1);
    step(0, 8'h00, 8'h00, 0, 1);
    step(0, 8'h00, 8'h00, 0, 1);
    chk("fl_par_enc", enc_data, enc(8'h03));
    chk("fl_par_addr", address_out, 8'h31);
    chk("fl_par_flag", out_is_parity, 1);
    chk("fl_idx_clr", stripe_idx, 0);
    step(0, 8'h00, 8'h00, 1, 1);
    step(0, 8'h00, 8'h00, 0, 1);
    step(0, 8'h00, 8'h00, 0, 1);
    chk("fl_empty_novalid", out_valid, 0);
    step(1, 8'h11, 8'h40, 0, 1);
    step(1, 8'h22, 8'h41, 0, 1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 8'(8'h80 + i), 8'(8'h50 + i), 0, 1);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 8'h00, 0, 1);
    chk("rst_fresh_drained", q.size(), 0);
    accepted = 0;
    cyc = 0;
    while (accepted < 10000 && cyc < 60000) begin
      step($urandom_range(9, 0) < 7, 8'($urandom), 8'($urandom), $urandom_range(49, 0) == 0, $urandom_range(9, 0) < 7);
      cyc++;
    end
    chk("rand_budget", accepted >= 10000, 1);
    for (int i = 0; i < 10; i++) step(0, 8'h00, 8'h00, 0, 1);
    chk("rand_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
